// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared phase encoding and lamp constants for the two-road phase scheduler.
package traffic_phase_scheduler_pkg;

    typedef enum logic [2:0] {
        StInitRed   = 3'd0,
        StPriGreen  = 3'd1,
        StPriYellow = 3'd2,
        StClearA    = 3'd3,
        StSecGreen  = 3'd4,
        StSecYellow = 3'd5,
        StPedWalk   = 3'd6,
        StClearB    = 3'd7
    } phase_e;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    function automatic logic [2:0] pri_lamp(phase_e ph);
        case (ph)
            StPriGreen:  return GRN;
            StPriYellow: return YEL;
            default:     return RED;
        endcase
    endfunction

    function automatic logic [2:0] sec_lamp(phase_e ph);
        case (ph)
            StSecGreen:  return GRN;
            StSecYellow: return YEL;
            default:     return RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Request inputs and lamp/debug outputs of the phase scheduler.
interface traffic_phase_scheduler_if;

    logic       secondaryRoadSensor;
    logic       pedRequest;
    logic [2:0] primaryRoadLight_RYG;
    logic [2:0] secondaryRoadLight_RYG;
    logic       pedWalk;
    logic [2:0] phase;

    modport master (
        output secondaryRoadSensor,
        output pedRequest,
        input  primaryRoadLight_RYG,
        input  secondaryRoadLight_RYG,
        input  pedWalk,
        input  phase
    );

    modport slave (
        input  secondaryRoadSensor,
        input  pedRequest,
        output primaryRoadLight_RYG,
        output secondaryRoadLight_RYG,
        output pedWalk,
        output phase
    );

endinterface

// File: rtl/traffic_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks; restart realigns it to a state entry.
module traffic_tick_gen #(
    parameter int unsigned TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Sensor-actuated phase FSM: primary road holds green by default and yields to either the
// secondary-road sensor or the pedestrian button, one requester per primary cycle.
module traffic_phase_scheduler
    import traffic_phase_scheduler_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 10_000_000,
    parameter int unsigned MIN_GREEN_PRI = 20,
    parameter int unsigned YELLOW_TICKS  = 3,
    parameter int unsigned ALL_RED_TICKS = 1,
    parameter int unsigned SEC_MIN_TICKS = 5,
    parameter int unsigned SEC_MAX_TICKS = 15,
    parameter int unsigned PED_TICKS     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    traffic_phase_scheduler_if.slave    bus
);

    localparam logic [7:0] AllRedLast  = 8'(ALL_RED_TICKS - 1);
    localparam logic [7:0] PriMinLast  = 8'(MIN_GREEN_PRI - 1);
    localparam logic [7:0] YellowLast  = 8'(YELLOW_TICKS - 1);
    localparam logic [7:0] SecMinLast  = 8'(SEC_MIN_TICKS - 1);
    localparam logic [7:0] SecMaxLast  = 8'(SEC_MAX_TICKS - 1);
    localparam logic [7:0] PedLast     = 8'(PED_TICKS - 1);

    phase_e     state_q, state_d;
    logic [7:0] t_q, t_d;
    logic       sec_pend_q, sec_pend_d;
    logic       ped_pend_q, ped_pend_d;
    logic       last_served_q, last_served_d;
    logic [2:0] pri_q, pri_d;
    logic [2:0] sec_q, sec_d;
    logic       walk_q, walk_d;
    logic       tick;
    logic       restart;

    traffic_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        if (tick) begin
            case (state_q)
                StInitRed:   if (t_q == AllRedLast) state_d = StPriGreen;
                StPriGreen:  if (t_q >= PriMinLast && (sec_pend_q || ped_pend_q)) begin
                    state_d = StPriYellow;
                end
                StPriYellow: if (t_q == YellowLast) state_d = StClearA;
                StClearA: begin
                    if (t_q == AllRedLast) begin
                        // On contention, grant whichever requester was not served last.
                        if (sec_pend_q && (!ped_pend_q || last_served_q)) begin
                            state_d       = StSecGreen;
                            last_served_d = 1'b0;
                        end else if (ped_pend_q) begin
                            state_d       = StPedWalk;
                            last_served_d = 1'b1;
                        end else begin
                            state_d = StPriGreen;
                        end
                    end
                end
                StSecGreen: begin
                    if ((t_q >= SecMinLast && !bus.secondaryRoadSensor) || t_q == SecMaxLast) begin
                        state_d = StSecYellow;
                    end
                end
                StSecYellow: if (t_q == YellowLast) state_d = StClearB;
                StPedWalk:   if (t_q == PedLast) state_d = StClearB;
                StClearB:    if (t_q == AllRedLast) state_d = StPriGreen;
                default:     state_d = StInitRed;
            endcase
        end
    end

    always_comb begin
        restart = (state_d != state_q);

        t_d = t_q;
        if (restart) begin
            t_d = 8'd0;
        end else if (tick && t_q != 8'hFF) begin
            t_d = t_q + 8'd1;
        end

        // Clearing on service entry takes priority over a same-cycle request.
        sec_pend_d = (sec_pend_q || bus.secondaryRoadSensor)
                     && !(restart && state_d == StSecGreen);
        ped_pend_d = (ped_pend_q || bus.pedRequest)
                     && !(restart && state_d == StPedWalk);

        pri_d  = pri_lamp(state_d);
        sec_d  = sec_lamp(state_d);
        walk_d = (state_d == StPedWalk);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StInitRed;
            t_q           <= 8'd0;
            sec_pend_q    <= 1'b0;
            ped_pend_q    <= 1'b0;
            last_served_q <= 1'b1;
            pri_q         <= RED;
            sec_q         <= RED;
            walk_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            t_q           <= t_d;
            sec_pend_q    <= sec_pend_d;
            ped_pend_q    <= ped_pend_d;
            last_served_q <= last_served_d;
            pri_q         <= pri_d;
            sec_q         <= sec_d;
            walk_q        <= walk_d;
        end
    end

    assign bus.primaryRoadLight_RYG   = pri_q;
    assign bus.secondaryRoadLight_RYG = sec_q;
    assign bus.pedWalk                = walk_q;
    assign bus.phase                  = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: a phase-level reference model predicts lamps each cycle; a monitor compares.
module tb_traffic_phase_scheduler;

    localparam int TD   = 4;
    localparam int MG   = 3;
    localparam int YT   = 2;
    localparam int AR   = 1;
    localparam int SMIN = 2;
    localparam int SMAX = 5;
    localparam int PT   = 3;

    // Phase indices follow the listed order: InitRed, PriGreen, PriYellow, ClearA,
    // SecGreen, SecYellow, PedWalk, ClearB.
    localparam int PH_INIT = 0, PH_PG = 1, PH_PY = 2, PH_CA = 3;
    localparam int PH_SG = 4, PH_SY = 5, PH_PW = 6, PH_CB = 7;

    typedef struct {
        int pri;
        int sec;
        int walk;
        int ph;
    } exp_t;

    logic clk;
    logic reset;
    traffic_phase_scheduler_if bus ();

    traffic_phase_scheduler #(
        .TICK_DIV     (TD),
        .MIN_GREEN_PRI(MG),
        .YELLOW_TICKS (YT),
        .ALL_RED_TICKS(AR),
        .SEC_MIN_TICKS(SMIN),
        .SEC_MAX_TICKS(SMAX),
        .PED_TICKS    (PT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_pass  = 0;
    int   n_total = 0;
    bit   mon_en  = 1'b0;
    exp_t sb[$];

    int pri_tbl[8]  = '{4, 1, 2, 4, 4, 4, 4, 4};
    int sec_tbl[8]  = '{4, 4, 4, 4, 1, 2, 4, 4};

    // Reference model state: current phase, cycles spent in it, request latches.
    int m_ph;
    int m_cyc;
    bit m_sec;
    bit m_ped;
    bit m_last;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic void model_reset();
        m_ph   = PH_INIT;
        m_cyc  = 0;
        m_sec  = 1'b0;
        m_ped  = 1'b0;
        m_last = 1'b1;
    endfunction

    // Advance the model across one clock edge given the inputs present before it.
    function automatic void model_step(input bit s, input bit p);
        int t;
        int nx;
        bit on_tick;
        on_tick = (m_cyc % TD) == TD - 1;
        t  = m_cyc / TD;
        if (t > 255) t = 255;
        nx = m_ph;
        if (on_tick) begin
            case (m_ph)
                PH_INIT: if (t == AR - 1) nx = PH_PG;
                PH_PG:   if (t >= MG - 1 && (m_sec || m_ped)) nx = PH_PY;
                PH_PY:   if (t == YT - 1) nx = PH_CA;
                PH_CA: begin
                    if (t == AR - 1) begin
                        if (m_sec && m_ped) nx = m_last ? PH_SG : PH_PW;
                        else if (m_sec)     nx = PH_SG;
                        else if (m_ped)     nx = PH_PW;
                        else                nx = PH_PG;
                        if (nx == PH_SG) m_last = 1'b0;
                        if (nx == PH_PW) m_last = 1'b1;
                    end
                end
                PH_SG:   if ((t >= SMIN - 1 && !s) || t == SMAX - 1) nx = PH_SY;
                PH_SY:   if (t == YT - 1) nx = PH_CB;
                PH_PW:   if (t == PT - 1) nx = PH_CB;
                default: if (t == AR - 1) nx = PH_PG;
            endcase
        end
        m_sec = (m_sec || s) && !(nx == PH_SG && m_ph != PH_SG);
        m_ped = (m_ped || p) && !(nx == PH_PW && m_ph != PH_PW);
        m_cyc = (nx != m_ph) ? 0 : m_cyc + 1;
        m_ph  = nx;
    endfunction

    // Called at a negedge: drive inputs, predict the post-edge outputs, wait one cycle.
    task automatic cycle(input bit s, input bit p);
        exp_t e;
        bus.secondaryRoadSensor = s;
        bus.pedRequest          = p;
        model_step(s, p);
        e.pri  = pri_tbl[m_ph];
        e.sec  = sec_tbl[m_ph];
        e.walk = (m_ph == PH_PW) ? 1 : 0;
        e.ph   = m_ph;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    function automatic bit rnd(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    // Monitor: compares every post-edge output against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_underflow: DUT output with no prediction at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("pri_lamp", int'(bus.primaryRoadLight_RYG), e.pri);
                    check("sec_lamp", int'(bus.secondaryRoadLight_RYG), e.sec);
                    check("ped_walk", int'(bus.pedWalk), e.walk);
                    check("phase", int'(bus.phase), e.ph);
                    check("safety_roads", int'(bus.primaryRoadLight_RYG != 3'b100
                          && bus.secondaryRoadLight_RYG != 3'b100), 0);
                    check("safety_walk", int'(bus.pedWalk && (bus.primaryRoadLight_RYG != 3'b100
                          || bus.secondaryRoadLight_RYG != 3'b100)), 0);
                end
            end
        end
    end

    initial begin
        int k;
        reset = 1'b1;
        bus.secondaryRoadSensor = 1'b0;
        bus.pedRequest          = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_pri", int'(bus.primaryRoadLight_RYG), 4);
        check("reset_sec", int'(bus.secondaryRoadLight_RYG), 4);
        check("reset_walk", int'(bus.pedWalk), 0);
        check("reset_phase", int'(bus.phase), PH_INIT);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;

        run_idle(20);                         // no requests: primary green held
        cycle(1'b1, 1'b0); run_idle(60);      // single sensor pulse
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0);
        run_idle(60);                         // sensor held: max secondary green
        cycle(1'b0, 1'b1); run_idle(60);      // pedestrian only
        cycle(1'b1, 1'b1); run_idle(120);     // contention: secondary first, then pedestrian
        for (int i = 0; i < 2000; i++) cycle(rnd(10), rnd(3));
        run_idle(40);

        // Reset in the middle of secondary green, between ticks.
        cycle(1'b1, 1'b0);
        k = 0;
        while (m_ph != PH_SG && k < 200) begin
            cycle(1'b1, 1'b0);
            k++;
        end
        if (m_ph != PH_SG) check("reach_sec_green", m_ph, PH_SG);
        cycle(1'b1, 1'b0);
        check("pre_reset_sec_green", int'(bus.secondaryRoadLight_RYG), 1);
        mon_en = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_pri", int'(bus.primaryRoadLight_RYG), 4);
        check("midreset_sec", int'(bus.secondaryRoadLight_RYG), 4);
        check("midreset_walk", int'(bus.pedWalk), 0);
        check("midreset_phase", int'(bus.phase), PH_INIT);
        bus.secondaryRoadSensor = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
        run_idle(20);
        cycle(1'b1, 1'b0); run_idle(60);

        mon_en = 1'b0;
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
